// File: rtl/soc_pkg.sv
// Shared constants for the single-cycle RV32I SoC: opcodes, funct3 codes,
// memory map and the ALU operation set.
package soc_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   localparam logic [3:0]  REGION_ROM = 4'h0;
   localparam logic [3:0]  REGION_RAM = 4'h1;
   localparam logic [31:0] IO_GPIO_ADDR = 32'h2000_0000;
   localparam logic [31:0] IO_HALT_ADDR = 32'h2000_0004;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   function automatic logic [31:0] sext8(input logic [7:0] b);
      return {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] h);
      return {{16{h[15]}}, h};
   endfunction

endpackage

// File: rtl/soc_regfile.sv
// 32x32 integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, all registers cleared by the async reset.
module soc_regfile (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_we,
   input  logic [4:0]  i_waddr,
   input  logic [31:0] i_wdata,
   input  logic [4:0]  i_raddr1,
   input  logic [4:0]  i_raddr2,
   output logic [31:0] o_rdata1,
   output logic [31:0] o_rdata2
);

   logic [31:0] r_regs [32];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else if (i_we && (i_waddr != 5'd0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : r_regs[i_raddr1];
   assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/soc_top.sv
// Single-cycle RV32I core with on-chip ROM, data RAM, a GPIO output register
// and a halt register; every instruction retires on one rising clk edge.
module soc_top
   import soc_pkg::*;
#(
   parameter int    ROM_WORDS = 1024,
   parameter int    RAM_WORDS = 1024,
   parameter string INIT_FILE = "firmware.hex"
) (
   input logic clk,
   input logic reset_n
);

   localparam int ROM_AW = $clog2(ROM_WORDS);
   localparam int RAM_AW = $clog2(RAM_WORDS);

   logic [31:0] r_rom [ROM_WORDS];
   logic [31:0] r_ram [RAM_WORDS];
   logic [31:0] r_pc;
   logic [31:0] gpio_out;
   logic        halt;

   logic [31:0] w_instr;
   logic [6:0]  w_opc;
   logic [4:0]  w_rd, w_rs1, w_rs2;
   logic [2:0]  w_f3;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic [31:0] w_rs1_val, w_rs2_val;

   // Fetch index is truncated to the ROM depth, so running off the end wraps.
   assign w_instr = r_rom[r_pc[ROM_AW+1:2]];
   assign w_opc   = w_instr[6:0];
   assign w_rd    = w_instr[11:7];
   assign w_f3    = w_instr[14:12];
   assign w_rs1   = w_instr[19:15];
   assign w_rs2   = w_instr[24:20];
   assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
   assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
   assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
   assign w_imm_u = {w_instr[31:12], 12'b0};
   assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

   logic        w_rd_we;
   logic [31:0] w_rd_data;

   soc_regfile u_regfile (
      .i_clk    (clk),
      .i_rst_n  (reset_n),
      .i_we     (w_rd_we && !halt),
      .i_waddr  (w_rd),
      .i_wdata  (w_rd_data),
      .i_raddr1 (w_rs1),
      .i_raddr2 (w_rs2),
      .o_rdata1 (w_rs1_val),
      .o_rdata2 (w_rs2_val)
   );

   alu_op_e     w_alu_op;
   logic [31:0] w_alu_b, w_alu_res;

   always_comb begin
      w_alu_op = ALU_ADD;
      case (w_f3)
         F3_ADD:  w_alu_op = (w_opc == OPC_OP && w_instr[30]) ? ALU_SUB : ALU_ADD;
         F3_SLL:  w_alu_op = ALU_SLL;
         F3_SLT:  w_alu_op = ALU_SLT;
         F3_SLTU: w_alu_op = ALU_SLTU;
         F3_XOR:  w_alu_op = ALU_XOR;
         F3_SR:   w_alu_op = w_instr[30] ? ALU_SRA : ALU_SRL;
         F3_OR:   w_alu_op = ALU_OR;
         F3_AND:  w_alu_op = ALU_AND;
         default: w_alu_op = ALU_ADD;
      endcase
   end

   assign w_alu_b = (w_opc == OPC_OP) ? w_rs2_val : w_imm_i;

   always_comb begin
      w_alu_res = '0;
      case (w_alu_op)
         ALU_ADD:  w_alu_res = w_rs1_val + w_alu_b;
         ALU_SUB:  w_alu_res = w_rs1_val - w_alu_b;
         ALU_SLL:  w_alu_res = w_rs1_val << w_alu_b[4:0];
         ALU_SLT:  w_alu_res = {31'b0, $signed(w_rs1_val) < $signed(w_alu_b)};
         ALU_SLTU: w_alu_res = {31'b0, w_rs1_val < w_alu_b};
         ALU_XOR:  w_alu_res = w_rs1_val ^ w_alu_b;
         ALU_SRL:  w_alu_res = w_rs1_val >> w_alu_b[4:0];
         ALU_SRA:  w_alu_res = $unsigned($signed(w_rs1_val) >>> w_alu_b[4:0]);
         ALU_OR:   w_alu_res = w_rs1_val | w_alu_b;
         ALU_AND:  w_alu_res = w_rs1_val & w_alu_b;
         default:  w_alu_res = '0;
      endcase
   end

   logic w_br_taken;

   always_comb begin
      w_br_taken = 1'b0;
      case (w_f3)
         F3_BEQ:  w_br_taken = (w_rs1_val == w_rs2_val);
         F3_BNE:  w_br_taken = (w_rs1_val != w_rs2_val);
         F3_BLT:  w_br_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
         F3_BGE:  w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
         F3_BLTU: w_br_taken = (w_rs1_val <  w_rs2_val);
         F3_BGEU: w_br_taken = (w_rs1_val >= w_rs2_val);
         default: w_br_taken = 1'b0;
      endcase
   end

   // Data address; for JALR this is also the jump target (I-type immediate).
   logic [31:0] w_addr, w_word_addr, w_rdata_word, w_lane, w_load_data;
   logic [3:0]  w_region;

   assign w_addr      = w_rs1_val + ((w_opc == OPC_STORE) ? w_imm_s : w_imm_i);
   assign w_word_addr = {w_addr[31:2], 2'b00};
   assign w_region    = w_addr[31:28];

   always_comb begin
      w_rdata_word = '0;
      if (w_region == REGION_ROM)          w_rdata_word = r_rom[w_addr[ROM_AW+1:2]];
      else if (w_region == REGION_RAM)     w_rdata_word = r_ram[w_addr[RAM_AW+1:2]];
      else if (w_word_addr == IO_GPIO_ADDR) w_rdata_word = gpio_out;
   end

   assign w_lane = w_rdata_word >> {w_addr[1:0], 3'b000};

   always_comb begin
      w_load_data = w_rdata_word;
      case (w_f3)
         F3_B:    w_load_data = sext8(w_lane[7:0]);
         F3_BU:   w_load_data = {24'b0, w_lane[7:0]};
         F3_H:    w_load_data = sext16(w_addr[1] ? w_rdata_word[31:16] : w_rdata_word[15:0]);
         F3_HU:   w_load_data = {16'b0, w_addr[1] ? w_rdata_word[31:16] : w_rdata_word[15:0]};
         default: w_load_data = w_rdata_word;
      endcase
   end

   logic [3:0]  w_st_be;
   logic [31:0] w_st_data;
   logic        w_is_store, w_ram_we, w_gpio_we, w_halt_we;

   always_comb begin
      w_st_be   = 4'b1111;
      w_st_data = w_rs2_val;
      case (w_f3[1:0])
         2'd0: begin
            w_st_be   = 4'b0001 << w_addr[1:0];
            w_st_data = {4{w_rs2_val[7:0]}};
         end
         2'd1: begin
            w_st_be   = w_addr[1] ? 4'b1100 : 4'b0011;
            w_st_data = {2{w_rs2_val[15:0]}};
         end
         default: begin
            w_st_be   = 4'b1111;
            w_st_data = w_rs2_val;
         end
      endcase
   end

   assign w_is_store = (w_opc == OPC_STORE) && !halt;
   assign w_ram_we   = w_is_store && (w_region == REGION_RAM);
   assign w_gpio_we  = w_is_store && (w_word_addr == IO_GPIO_ADDR);
   assign w_halt_we  = w_is_store && (w_word_addr == IO_HALT_ADDR);

   logic [31:0] w_pc_plus4, w_pc_next;

   assign w_pc_plus4 = r_pc + 32'd4;

   always_comb begin
      w_rd_we   = 1'b0;
      w_rd_data = '0;
      w_pc_next = w_pc_plus4;
      case (w_opc)
         OPC_LUI:    begin w_rd_we = 1'b1; w_rd_data = w_imm_u; end
         OPC_AUIPC:  begin w_rd_we = 1'b1; w_rd_data = r_pc + w_imm_u; end
         OPC_JAL: begin
            w_rd_we   = 1'b1;
            w_rd_data = w_pc_plus4;
            w_pc_next = r_pc + w_imm_j;
         end
         OPC_JALR: begin
            w_rd_we   = 1'b1;
            w_rd_data = w_pc_plus4;
            w_pc_next = w_addr & ~32'd1;
         end
         OPC_BRANCH: if (w_br_taken) w_pc_next = r_pc + w_imm_b;
         OPC_OPIMM,
         OPC_OP:     begin w_rd_we = 1'b1; w_rd_data = w_alu_res; end
         OPC_LOAD:   begin w_rd_we = 1'b1; w_rd_data = w_load_data; end
         default:    w_pc_next = w_pc_plus4;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc     <= '0;
         gpio_out <= '0;
         halt     <= 1'b0;
      end else if (!halt) begin
         r_pc <= w_pc_next;
         if (w_halt_we) halt <= 1'b1;
         if (w_gpio_we) begin
            for (int b = 0; b < 4; b++)
               if (w_st_be[b]) gpio_out[b*8 +: 8] <= w_st_data[b*8 +: 8];
         end
      end
   end

   // RAM has no reset: its contents survive reset_n.
   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         for (int b = 0; b < 4; b++)
            if (w_st_be[b]) r_ram[w_addr[RAM_AW+1:2]][b*8 +: 8] <= w_st_data[b*8 +: 8];
      end
   end

endmodule

// File: tb/tb_soc_top.sv
// Directed bench for soc_top: programs are assembled into the ROM through a
// hierarchical reference, then architectural state is compared to hand values.
module tb_soc_top;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] prog [$];

   always #5 clk = ~clk;

   soc_top #(.ROM_WORDS(1024), .RAM_WORDS(1024), .INIT_FILE("")) u_dut (
      .clk     (clk),
      .reset_n (reset_n)
   );

   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] opc);
      logic [31:0] v = imm;
      logic [31:0] a = rs1, f = f3, d = rd;
      return {v[11:0], a[4:0], f[2:0], d[4:0], opc};
   endfunction
   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
      logic [31:0] v = imm;
      logic [31:0] b = rs2, a = rs1, f = f3;
      return {v[11:5], b[4:0], a[4:0], f[2:0], v[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
      logic [31:0] v = imm;
      logic [31:0] b = rs2, a = rs1, f = f3;
      return {v[12], v[10:5], b[4:0], a[4:0], f[2:0], v[4:1], v[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] opc);
      logic [31:0] v = imm20;
      logic [31:0] d = rd;
      return {v[19:0], d[4:0], opc};
   endfunction
   function automatic logic [31:0] enc_j(int imm, int rd);
      logic [31:0] v = imm;
      logic [31:0] d = rd;
      return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'b1101111};
   endfunction
   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      logic [31:0] s = f7, b = rs2, a = rs1, f = f3, d = rd;
      return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
   endfunction
   function automatic logic [31:0] addi(int rd, int rs1, int imm);
      return enc_i(imm, rs1, 0, rd, 7'b0010011);
   endfunction
   function automatic logic [31:0] lui(int rd, int imm20);
      return enc_u(imm20, rd, 7'b0110111);
   endfunction
   function automatic logic [31:0] ld(int f3, int rd, int rs1, int imm);
      return enc_i(imm, rs1, f3, rd, 7'b0000011);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start();
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 1024; i++) u_dut.r_rom[i] = 32'h0;
      for (int i = 0; i < prog.size(); i++) u_dut.r_rom[i] = prog[i];
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // GPIO store of a negative sum
      prog = {addi(1, 0, 5), addi(2, 1, -7), lui(3, 32'h20000), enc_s(0, 2, 3, 2)};
      start();
      reset_n = 1'b0;
      #1;
      chk("rst_pc", u_dut.r_pc, 32'h0);
      chk("rst_gpio", u_dut.gpio_out, 32'h0);
      chk("rst_halt", {31'b0, u_dut.halt}, 32'h0);
      chk("rst_x1", u_dut.u_regfile.r_regs[1], 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      run(4);
      chk("t1_gpio", u_dut.gpio_out, 32'hFFFF_FFFE);
      chk("t1_x2", u_dut.u_regfile.r_regs[2], 32'hFFFF_FFFE);
      chk("t1_pc", u_dut.r_pc, 32'h10);

      // RAM byte/half/word accesses, unmapped load, ROM store ignored
      prog = {lui(1, 32'h10000), addi(2, 0, 32'h1A5), lui(5, 32'h12345), addi(5, 5, 32'h678),
              enc_s(0, 5, 1, 2), enc_s(1, 2, 1, 0), ld(2, 3, 1, 0), ld(0, 4, 1, 1),
              ld(4, 6, 1, 1), ld(1, 7, 1, 2), ld(5, 8, 1, 0), lui(9, 32'h30000),
              addi(10, 0, -1), ld(2, 10, 9, 0), enc_s(0, 5, 0, 2), ld(2, 11, 0, 0),
              enc_s(3, 2, 1, 1), ld(2, 13, 1, 3)};
      start();
      run(18);
      chk("t2_lw", u_dut.u_regfile.r_regs[3], 32'h1234_A578);
      chk("t2_lb", u_dut.u_regfile.r_regs[4], 32'hFFFF_FFA5);
      chk("t2_lbu", u_dut.u_regfile.r_regs[6], 32'h0000_00A5);
      chk("t2_lh", u_dut.u_regfile.r_regs[7], 32'h0000_1234);
      chk("t2_lhu", u_dut.u_regfile.r_regs[8], 32'h0000_A578);
      chk("t2_unmapped", u_dut.u_regfile.r_regs[10], 32'h0);
      chk("t2_rom_ro", u_dut.u_regfile.r_regs[11], prog[0]);
      chk("t2_sh_mis", u_dut.u_regfile.r_regs[13], 32'h01A5_A578);

      // Countdown loop, then GPIO write and halt
      prog = {lui(3, 32'h20000), addi(2, 0, 32'h77), enc_s(0, 2, 3, 2), addi(1, 0, 10),
              addi(1, 1, -1), enc_b(-4, 0, 1, 1), enc_s(0, 1, 3, 2), enc_s(4, 0, 3, 2),
              addi(5, 0, 1)};
      start();
      run(3);
      chk("t3_gpio_pre", u_dut.gpio_out, 32'h77);
      run(23);
      chk("t3_halt", {31'b0, u_dut.halt}, 32'h1);
      chk("t3_gpio", u_dut.gpio_out, 32'h0);
      chk("t3_pc", u_dut.r_pc, 32'h20);
      run(20000);
      chk("t3_pc_frozen", u_dut.r_pc, 32'h20);
      chk("t3_x5", u_dut.u_regfile.r_regs[5], 32'h0);
      chk("t3_gpio_frozen", u_dut.gpio_out, 32'h0);

      // JAL/JALR, with ECALL and an all-zero word acting as NOPs
      prog = {addi(0, 0, 0), 32'h0000_0073, 32'h0, addi(0, 0, 0),
              enc_j(8, 1), addi(2, 2, 1), enc_i(1, 1, 0, 0, 7'b1100111)};
      start();
      run(5);
      chk("t4_link", u_dut.u_regfile.r_regs[1], 32'h14);
      chk("t4_jal_pc", u_dut.r_pc, 32'h18);
      run(1);
      chk("t4_jalr_pc", u_dut.r_pc, 32'h14);
      run(1);
      chk("t4_x2", u_dut.u_regfile.r_regs[2], 32'h1);

      // ALU corners and branches
      prog = {lui(1, 32'h80000), enc_i(32'h404, 1, 5, 2, 7'b0010011), enc_r(0, 1, 0, 3, 3),
              addi(0, 0, 5), enc_r(0, 0, 1, 2, 4), enc_i(4, 1, 5, 5, 7'b0010011),
              enc_r(32'h20, 3, 0, 0, 6), enc_b(8, 0, 1, 4), addi(7, 0, 1), enc_b(8, 0, 1, 6),
              addi(8, 0, 2), enc_b(8, 1, 0, 5), addi(9, 0, 3), enc_u(1, 10, 7'b0010111),
              enc_i(32'hF0, 6, 4, 11, 7'b0010011), enc_r(0, 8, 8, 1, 12),
              enc_r(32'h20, 8, 1, 5, 13), enc_r(0, 8, 3, 6, 15)};
      start();
      run(16);
      chk("t5_srai", u_dut.u_regfile.r_regs[2], 32'hF800_0000);
      chk("t5_sltu", u_dut.u_regfile.r_regs[3], 32'h1);
      chk("t5_x0", u_dut.u_regfile.r_regs[0], 32'h0);
      chk("t5_slt", u_dut.u_regfile.r_regs[4], 32'h1);
      chk("t5_srli", u_dut.u_regfile.r_regs[5], 32'h0800_0000);
      chk("t5_sub", u_dut.u_regfile.r_regs[6], 32'hFFFF_FFFF);
      chk("t5_blt_skip", u_dut.u_regfile.r_regs[7], 32'h0);
      chk("t5_bltu_fall", u_dut.u_regfile.r_regs[8], 32'h2);
      chk("t5_bge_skip", u_dut.u_regfile.r_regs[9], 32'h0);
      chk("t5_auipc", u_dut.u_regfile.r_regs[10], 32'h0000_1034);
      chk("t5_xori", u_dut.u_regfile.r_regs[11], 32'hFFFF_FF0F);
      chk("t5_sll", u_dut.u_regfile.r_regs[12], 32'h8);
      chk("t5_sra", u_dut.u_regfile.r_regs[13], 32'hE000_0000);
      chk("t5_or", u_dut.u_regfile.r_regs[15], 32'h3);
      chk("t5_pc", u_dut.r_pc, 32'h48);

      // Asynchronous reset between edges, then restart
      prog = {addi(1, 0, 5), addi(2, 1, -7), lui(3, 32'h20000), enc_s(0, 2, 3, 2)};
      start();
      run(6);
      chk("t6_gpio_pre", u_dut.gpio_out, 32'hFFFF_FFFE);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_pc", u_dut.r_pc, 32'h0);
      chk("t6_gpio", u_dut.gpio_out, 32'h0);
      chk("t6_x1", u_dut.u_regfile.r_regs[1], 32'h0);
      chk("t6_x3", u_dut.u_regfile.r_regs[3], 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      run(1);
      chk("t6_restart_x1", u_dut.u_regfile.r_regs[1], 32'h5);
      chk("t6_restart_pc", u_dut.r_pc, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/soc_top.md
SOC_TOP -- requirements
Module: soc_top

Interface
REQ-001 Parameter ROM_WORDS, default 1024: instruction ROM depth in 32-bit words.
REQ-002 Parameter RAM_WORDS, default 1024: data RAM depth in 32-bit words.
REQ-003 Parameter INIT_FILE, default "firmware.hex": $readmemh image loaded into ROM at elaboration.
REQ-004 clk  input  1  single system clock, all state on rising edge, nominal 30 MHz.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have no other ports; the GPIO output register gpio_out (32 bits) and the halt flag SHALL be internal signals reachable by hierarchical reference.

Function
REQ-007 The block SHALL execute RV32I base instructions single-cycle, one instruction retired per rising clk edge when not halted.
REQ-008 Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW/LH/LHU/LB/LBU, SW/SH/SB, all OP-IMM and OP ALU forms; FENCE, ECALL, CSR and unknown opcodes SHALL execute as NOP (PC+4).
REQ-009 Memory map: ROM 0x0000_0000 (read-only, combinational fetch); RAM 0x1000_0000 (combinational read, write on clk edge, byte enables); GPIO_OUT 0x2000_0000 (R/W, 32 bits); HALT 0x2000_0004 (write any value sets halt).
REQ-010 Address decode SHALL use addr[31:28]; word index = addr[..:2] truncated to depth (wrap-around inside region).
REQ-011 Loads from unmapped space SHALL return 0; stores to unmapped or ROM space SHALL be ignored.
REQ-012 Sub-word loads SHALL select lanes by addr[1:0] and sign/zero extend; misaligned word/half accesses SHALL use the aligned word (addr[1:0] ignored for LW, addr[0] ignored for LH/SH).
REQ-013 Register x0 SHALL read 0 and ignore writes; other writes take effect at the same edge as the PC update.
REQ-014 Shifts SHALL use rs2/imm[4:0]; SRA/SRAI arithmetic; SLT signed, SLTU unsigned; add/sub wrap modulo 2^32.
REQ-015 JALR target SHALL clear bit 0; branch/jump targets SHALL not be alignment-checked (bit 1 ignored by fetch).
REQ-016 Once halt is set the PC, register file, RAM and GPIO SHALL freeze until reset.
REQ-017 Fetch past ROM end SHALL wrap to ROM word 0 (index truncation).

Reset
REQ-018 While reset_n=0: PC=0x0000_0000, x1..x31=0, gpio_out=0, halt=0; RAM contents unspecified and not cleared.
REQ-019 Reset assertion SHALL take effect immediately regardless of clk; first instruction (ROM word 0) executes at the first rising edge after reset_n releases.
REQ-020 X on reset_n before first valid low SHALL not be required to produce defined state; defined behaviour starts from first reset_n=0 pulse.

Structure
REQ-021 Shared package soc_pkg SHALL hold opcode/funct3 constants, region base addresses and ALU operation enum.
REQ-022 One sub-module soc_regfile (32x32, two combinational read ports, one write port, async reset) SHALL be used; ALU, decode, memories and bus decode SHALL stay in soc_top.

Verification
REQ-023 ROM: ADDI x1,x0,5; ADDI x2,x1,-7; SW x2,0(GPIO) -> after 3 edges past reset gpio_out=0xFFFF_FFFE.
REQ-024 ROM: LUI x1,0x10000; ADDI x2,x0,0x1A5; SB x2,1(x1); LW x3,0(x1); LB x4,1(x1) -> x3 byte1=0xA5 (other bytes unchanged), x4=0xFFFF_FFA5.
REQ-025 Loop: x1=10, decrement, BNE back, then SW x1 to GPIO, SW to HALT -> gpio_out=0 and PC constant thereafter across 20000 cycles.
REQ-026 JAL x1,+8 at 0x10 -> x1=0x14, next PC 0x18; JALR x0,1(x1) -> PC=0x14.
REQ-027 Assert reset_n=0 mid-program between clk edges -> PC, gpio_out, x1..x31 read 0 within the same cycle; run restarts from 0 after release.
REQ-028 SRAI x2,x1,4 with x1=0x8000_0000 -> 0xF800_0000; SLTU x3,x0,x1 -> 1; ADDI x0,x0,5 -> x0 stays 0.
